data_mem_resp: RTL and testbench

DATA_MEM_RESP -- requirements
Module: data_mem_resp

---
 rtl/data_mem_resp.sv | 132 +++++++++++++
 tb/tb_data_mem_resp.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/data_mem_resp.sv
// Word-addressed data memory with a fixed-latency request/response handshake.
// Requests are captured in IDLE, aged in WAIT, and reported with a one-cycle ready pulse in DONE.
module data_mem_resp #(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memread,
  input  logic        memwrite,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        misalign,
  output logic        busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = 4;

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [AW+1:0]   addr_q, addr_d;
  logic [31:0]     wdata_q, wdata_d;
  logic            wr_q, wr_d;
  logic            ready_q, ready_d;
  logic            misalign_q, misalign_d;
  logic            busy_q, busy_d;
  logic [31:0]     rdata_q;
  logic            mem_we, mem_re;
  logic            finishing;
  logic            aligned;
  logic [AW-1:0]   idx;
  logic            unused_addr_hi;

  logic [31:0] mem [DEPTH];

  // Upper address bits simply wrap; they never reach the memory index.
  assign unused_addr_hi = ^addr[31:AW+2];

  assign idx       = addr_q[AW+1:2];
  assign aligned   = (addr_q[1:0] == 2'b00);
  assign finishing = (state_q == WAIT) && (cnt_q == '0);
  assign mem_we    = finishing && wr_q && aligned;
  assign mem_re    = finishing && !wr_q && aligned;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    wr_d       = wr_q;
    ready_d    = 1'b0;
    misalign_d = 1'b0;
    busy_d     = busy_q;
    case (state_q)
      IDLE: begin
        if (memread || memwrite) begin
          state_d = WAIT;
          cnt_d   = CW'(LATENCY - 1);
          addr_d  = addr[AW+1:0];
          wdata_d = wdata;
          wr_d    = memwrite;
          busy_d  = 1'b1;
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          state_d    = DONE;
          ready_d    = 1'b1;
          misalign_d = !aligned;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      wr_q       <= 1'b0;
      ready_q    <= 1'b0;
      misalign_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      wr_q       <= wr_d;
      ready_q    <= ready_d;
      misalign_q <= misalign_d;
      busy_q     <= busy_d;
    end
  end

  // Memory contents survive reset; only an un-reset commit may write.
  always_ff @(posedge clk) begin
    if (mem_we && !reset) begin
      mem[idx] <= wdata_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rdata_q <= '0;
    end else if (mem_re) begin
      rdata_q <= mem[idx];
    end
  end

  assign rdata    = rdata_q;
  assign ready    = ready_q;
  assign misalign = misalign_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_data_mem_resp.sv
// Directed bench for data_mem_resp with default DEPTH=256, LATENCY=2.
module tb_data_mem_resp;

  logic        clk = 1'b0;
  logic        reset;
  logic        memread;
  logic        memwrite;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ready;
  logic        misalign;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  data_mem_resp dut (
    .clk      (clk),
    .reset    (reset),
    .memread  (memread),
    .memwrite (memwrite),
    .addr     (addr),
    .wdata    (wdata),
    .rdata    (rdata),
    .ready    (ready),
    .misalign (misalign),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full transaction: accept, wait for ready, check completion, return to IDLE.
  task automatic txn(input string tag, input logic rd, input logic wr,
                     input logic [31:0] a, input logic [31:0] d, input bit scramble,
                     input logic exp_mis, input logic [31:0] exp_rdata);
    int n;
    memread  = rd;
    memwrite = wr;
    addr     = a;
    wdata    = d;
    step();
    check({tag, "_busy"}, {31'd0, busy}, 32'd1);
    check({tag, "_noready"}, {31'd0, ready}, 32'd0);
    if (!scramble) begin
      memread  = 1'b0;
      memwrite = 1'b0;
    end
    n = 0;
    while (!ready && n < 20) begin
      if (scramble) begin
        memread  = 1'b1;
        memwrite = 1'($urandom_range(0, 1));
        addr     = $urandom;
        wdata    = $urandom;
      end
      step();
      n++;
    end
    check({tag, "_latency"}, n, 32'd2);
    check({tag, "_misalign"}, {31'd0, misalign}, {31'd0, exp_mis});
    check({tag, "_rdata"}, rdata, exp_rdata);
    $display("txn %s rd=%0b wr=%0b addr=0x%08h wdata=0x%08h -> rdata=0x%08h misalign=%0b cycles=%0d",
             tag, rd, wr, a, d, rdata, misalign, n);
    memread  = 1'b0;
    memwrite = 1'b0;
    step();
    check({tag, "_idle_ready"}, {31'd0, ready}, 32'd0);
    check({tag, "_idle_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_idle_mis"}, {31'd0, misalign}, 32'd0);
  endtask

  initial begin
    reset    = 1'b1;
    memread  = 1'b0;
    memwrite = 1'b1;
    addr     = 32'h10;
    wdata    = 32'h1;
    step();
    step();
    check("rst_ready", {31'd0, ready}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_misalign", {31'd0, misalign}, 32'd0);
    check("rst_rdata", rdata, 32'd0);
    memwrite = 1'b0;
    reset    = 1'b0;
    step();

    txn("wr10", 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0, 1'b0, 32'h0);
    txn("rd10", 1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 32'hDEADBEEF);
    txn("rd402", 1'b1, 1'b0, 32'h402, 32'h0, 1'b0, 1'b1, 32'hDEADBEEF);
    txn("wr0", 1'b0, 1'b1, 32'h0, 32'hCAFEF00D, 1'b0, 1'b0, 32'hDEADBEEF);
    txn("wr401", 1'b0, 1'b1, 32'h401, 32'hBAD0BAD0, 1'b0, 1'b1, 32'hDEADBEEF);
    txn("rd0", 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'hCAFEF00D);
    txn("wr400", 1'b0, 1'b1, 32'h400, 32'h11111111, 1'b0, 1'b0, 32'hCAFEF00D);
    txn("rd0wrap", 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h11111111);
    txn("rdwr8", 1'b1, 1'b1, 32'h8, 32'hA5A5A5A5, 1'b0, 1'b0, 32'h11111111);
    txn("rd8", 1'b1, 1'b0, 32'h8, 32'h0, 1'b0, 1'b0, 32'hA5A5A5A5);
    txn("wr20", 1'b0, 1'b1, 32'h20, 32'h0BADF00D, 1'b0, 1'b0, 32'hA5A5A5A5);

    // Write aborted by reset while in WAIT.
    memwrite = 1'b1;
    addr     = 32'h20;
    wdata    = 32'h12345678;
    step();
    check("abort_busy_pre", {31'd0, busy}, 32'd1);
    memwrite = 1'b0;
    reset    = 1'b1;
    step();
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_ready", {31'd0, ready}, 32'd0);
    check("abort_rdata", rdata, 32'd0);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      check("abort_noready", {31'd0, ready}, 32'd0);
    end
    txn("rd20", 1'b1, 1'b0, 32'h20, 32'h0, 1'b0, 1'b0, 32'h0BADF00D);

    // Inputs churn every cycle while busy; only captured values count.
    txn("wr30s", 1'b0, 1'b1, 32'h30, 32'h600DCAFE, 1'b1, 1'b0, 32'h0BADF00D);
    txn("rd30s", 1'b1, 1'b0, 32'h30, 32'h0, 1'b1, 1'b0, 32'h600DCAFE);
    txn("rd20b", 1'b1, 1'b0, 32'h20, 32'h0, 1'b0, 1'b0, 32'h0BADF00D);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
